// File: rtl/instr_lag_monitor_if.sv
// instr_lag_monitor_if
//   Bundles the original/delayed instruction streams and the monitor's status
//   outputs so a producer (master) and the lag monitor (slave) share one port.
//   master: drives orig_instr, delayed_instr, orig_data, delayed_data;
//           observes synced, lag_err, data_err, outstanding, state.
//   slave : the reverse direction of every signal.
interface instr_lag_monitor_if #(
  parameter int NUM_INSTR     = 4,
  parameter int NUM_DATA_BITS = 64,
  parameter int MAX_LAG       = 1
);
  localparam int OUTW = $clog2(NUM_INSTR * MAX_LAG + 1);

  logic [NUM_INSTR-1:0]     orig_instr;
  logic [NUM_INSTR-1:0]     delayed_instr;
  logic [NUM_DATA_BITS-1:0] orig_data;
  logic [NUM_DATA_BITS-1:0] delayed_data;
  logic                     synced;
  logic                     lag_err;
  logic                     data_err;
  logic [OUTW-1:0]          outstanding;
  logic [1:0]               state;

  modport master (
    output orig_instr, delayed_instr, orig_data, delayed_data,
    input  synced, lag_err, data_err, outstanding, state
  );

  modport slave (
    input  orig_instr, delayed_instr, orig_data, delayed_data,
    output synced, lag_err, data_err, outstanding, state
  );
endinterface

// File: rtl/instr_lag_monitor.sv
// instr_lag_monitor
//   Watches an original and a delayed instruction stream, keeps a signed lag
//   counter per lane, buffers the data of DATA_LANE issues from the original
//   stream and compares it against the delayed stream's data. Flags lag
//   divergence, buffer misuse and data mismatches; reports when both streams
//   are back in sync. All outputs are registered.
//   Ports: clk, rst (async, active-high), bus (instr_lag_monitor_if.slave):
//     orig_instr/delayed_instr/orig_data/delayed_data in,
//     synced/lag_err/data_err/outstanding/state out.
module instr_lag_monitor #(
  parameter int NUM_INSTR     = 4,
  parameter int NUM_DATA_BITS = 64,
  parameter int DATA_LANE     = 0,
  parameter int MAX_LAG       = 1,
  parameter int DEPTH         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_lag_monitor_if.slave   bus
);

  localparam int LAGW = $clog2(MAX_LAG + 2) + 1;
  localparam int OUTW = $clog2(NUM_INSTR * MAX_LAG + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int OUT_SAT = (1 << OUTW) - 1;

  localparam logic signed [LAGW-1:0] LAG_ONE   = LAGW'(1);
  localparam logic signed [LAGW-1:0] LAG_LIMIT = LAGW'(MAX_LAG);
  localparam logic signed [LAGW-1:0] LAG_HI    = {1'b0, {(LAGW-1){1'b1}}};
  localparam logic signed [LAGW-1:0] LAG_LO    = {1'b1, {(LAGW-1){1'b0}}};
  localparam logic [CNTW-1:0]        CNT_FULL  = CNTW'(DEPTH);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_LAG  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  logic signed [LAGW-1:0]   lag_q [NUM_INSTR];
  logic signed [LAGW-1:0]   lag_d [NUM_INSTR];
  logic [NUM_DATA_BITS-1:0] mem [DEPTH];
  logic [PTRW-1:0]          rd_ptr_q, wr_ptr_q;
  logic [CNTW-1:0]          count_q, count_d;
  logic                     do_write, do_read, cmp_valid, buf_err;
  logic [NUM_DATA_BITS-1:0] cmp_word;
  logic                     range_bad, all_zero;
  int                       acc;
  logic                     synced_q, synced_d;
  logic                     lag_err_q, lag_err_d;
  logic                     data_err_q, data_err_d;
  logic [OUTW-1:0]          outstanding_q, outstanding_d;
  state_t                   state_q, state_d;
  logic                     push, pop;

  assign push = bus.orig_instr[DATA_LANE];
  assign pop  = bus.delayed_instr[DATA_LANE];

  // Lag counters saturate instead of wrapping so that, once in ERR, a runaway
  // stream cannot fold back into a value that looks legal. The outstanding
  // sum saturates at its port width for the same reason.
  always_comb begin
    range_bad = 1'b0;
    all_zero  = 1'b1;
    acc       = 0;
    for (int i = 0; i < NUM_INSTR; i++) begin
      lag_d[i] = lag_q[i];
      if (bus.orig_instr[i] && !bus.delayed_instr[i] && lag_q[i] != LAG_HI)
        lag_d[i] = lag_q[i] + LAG_ONE;
      else if (!bus.orig_instr[i] && bus.delayed_instr[i] && lag_q[i] != LAG_LO)
        lag_d[i] = lag_q[i] - LAG_ONE;
      if (lag_d[i][LAGW-1] || lag_d[i] > LAG_LIMIT)
        range_bad = 1'b1;
      if (lag_d[i] != '0)
        all_zero = 1'b0;
      if (!lag_d[i][LAGW-1])
        acc = acc + int'(lag_d[i]);
    end
    outstanding_d = (acc > OUT_SAT) ? OUTW'(OUT_SAT) : OUTW'(acc);
  end

  // Data FIFO control. A push and pop together on an empty buffer bypasses
  // storage entirely; on a non-empty buffer the head is read and the new word
  // written in the same cycle, which also works when full since the head slot
  // is freed by the read.
  always_comb begin
    do_write  = 1'b0;
    do_read   = 1'b0;
    cmp_valid = 1'b0;
    cmp_word  = mem[rd_ptr_q];
    buf_err   = 1'b0;
    count_d   = count_q;
    if (push && pop) begin
      cmp_valid = 1'b1;
      if (count_q == '0) begin
        cmp_word = bus.orig_data;
      end else begin
        do_read  = 1'b1;
        do_write = 1'b1;
      end
    end else if (push) begin
      if (count_q == CNT_FULL) begin
        buf_err = 1'b1;
      end else begin
        do_write = 1'b1;
        count_d  = count_q + CNTW'(1);
      end
    end else if (pop) begin
      if (count_q == '0) begin
        buf_err = 1'b1;
      end else begin
        do_read   = 1'b1;
        cmp_valid = 1'b1;
        count_d   = count_q - CNTW'(1);
      end
    end
  end

  // Sticky flags and sync status, all derived from the updated counters.
  always_comb begin
    lag_err_d  = lag_err_q | range_bad | buf_err;
    data_err_d = data_err_q | (cmp_valid && (cmp_word != bus.delayed_data));
    synced_d   = all_zero && (count_d == '0);
  end

  // Next-state logic. Flags are sticky, so ERR holds until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: if (!synced_d) state_d = ST_LAG;
      ST_LAG:  if (synced_d)  state_d = ST_SYNC;
      default: state_d = ST_ERR;
    endcase
    if (lag_err_d || data_err_d)
      state_d = ST_ERR;
  end

  // Counter, pointer, flag and state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_INSTR; i++)
        lag_q[i] <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      synced_q      <= 1'b1;
      lag_err_q     <= 1'b0;
      data_err_q    <= 1'b0;
      outstanding_q <= '0;
      state_q       <= ST_SYNC;
    end else begin
      for (int i = 0; i < NUM_INSTR; i++)
        lag_q[i] <= lag_d[i];
      if (do_read)
        rd_ptr_q <= rd_ptr_q + PTRW'(1);
      if (do_write)
        wr_ptr_q <= wr_ptr_q + PTRW'(1);
      count_q       <= count_d;
      synced_q      <= synced_d;
      lag_err_q     <= lag_err_d;
      data_err_q    <= data_err_d;
      outstanding_q <= outstanding_d;
      state_q       <= state_d;
    end
  end

  // Buffer storage needs no reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr_q] <= bus.orig_data;
  end

  assign bus.synced      = synced_q;
  assign bus.lag_err     = lag_err_q;
  assign bus.data_err    = data_err_q;
  assign bus.outstanding = outstanding_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_instr_lag_monitor.sv
// tb_instr_lag_monitor
//   Drives directed scenarios and randomized instruction/data streams into
//   instr_lag_monitor and compares every registered output against a
//   queue-based reference model of lag counting and in-order data matching.
module tb_instr_lag_monitor;

  localparam int NI      = 4;
  localparam int DW      = 64;
  localparam int ML      = 1;
  localparam int DEPTH   = 4;
  localparam int LAG_MIN = -4;
  localparam int LAG_MAX = 3;
  localparam int OUT_SAT = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;

  instr_lag_monitor_if #(.NUM_INSTR(NI), .NUM_DATA_BITS(DW), .MAX_LAG(ML)) bus ();

  instr_lag_monitor #(
    .NUM_INSTR(NI), .NUM_DATA_BITS(DW), .DATA_LANE(0), .MAX_LAG(ML), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int            m_lag [NI];
  logic [DW-1:0] m_q [$];
  bit            m_lag_err, m_data_err, m_synced;
  int            m_state, m_out;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NI; i++) m_lag[i] = 0;
    m_q.delete();
    m_lag_err = 0; m_data_err = 0; m_synced = 1; m_state = 0; m_out = 0;
  endtask

  task automatic modelStep(input logic [NI-1:0] o, input logic [NI-1:0] d,
                           input logic [DW-1:0] od, input logic [DW-1:0] dd);
    logic [DW-1:0] head;
    int sum;
    sum = 0;
    for (int i = 0; i < NI; i++) begin
      if (o[i] && !d[i] && m_lag[i] < LAG_MAX) m_lag[i]++;
      if (!o[i] && d[i] && m_lag[i] > LAG_MIN) m_lag[i]--;
      if (m_lag[i] < 0 || m_lag[i] > ML) m_lag_err = 1;
    end
    if (o[0] && d[0]) begin
      if (m_q.size() == 0) begin
        if (od != dd) m_data_err = 1;
      end else begin
        head = m_q.pop_front();
        if (head != dd) m_data_err = 1;
        m_q.push_back(od);
      end
    end else if (o[0]) begin
      if (m_q.size() == DEPTH) m_lag_err = 1;
      else m_q.push_back(od);
    end else if (d[0]) begin
      if (m_q.size() == 0) m_lag_err = 1;
      else begin
        head = m_q.pop_front();
        if (head != dd) m_data_err = 1;
      end
    end
    m_synced = (m_q.size() == 0);
    for (int i = 0; i < NI; i++) begin
      if (m_lag[i] != 0) m_synced = 0;
      if (m_lag[i] > 0) sum += m_lag[i];
    end
    m_out = (sum > OUT_SAT) ? OUT_SAT : sum;
    if (m_state != 2) begin
      if (m_lag_err || m_data_err) m_state = 2;
      else m_state = m_synced ? 0 : 1;
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".synced"},      64'(bus.synced),      64'(m_synced));
    checkOutput({tag, ".lag_err"},     64'(bus.lag_err),     64'(m_lag_err));
    checkOutput({tag, ".data_err"},    64'(bus.data_err),    64'(m_data_err));
    checkOutput({tag, ".outstanding"}, 64'(bus.outstanding), 64'(m_out));
    checkOutput({tag, ".state"},       64'(bus.state),       64'(m_state));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".synced"},      64'(bus.synced),      64'd1);
    checkOutput({tag, ".lag_err"},     64'(bus.lag_err),     64'd0);
    checkOutput({tag, ".data_err"},    64'(bus.data_err),    64'd0);
    checkOutput({tag, ".outstanding"}, 64'(bus.outstanding), 64'd0);
    checkOutput({tag, ".state"},       64'(bus.state),       64'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [NI-1:0] o, input logic [NI-1:0] d,
                               input logic [DW-1:0] od, input logic [DW-1:0] dd);
    @(negedge clk);
    bus.orig_instr    = o;
    bus.delayed_instr = d;
    bus.orig_data     = od;
    bus.delayed_data  = dd;
    @(posedge clk);
    #1;
    modelStep(o, d, od, dd);
    checkAll(tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    bus.orig_instr    = '0;
    bus.delayed_instr = '0;
    bus.orig_data     = '0;
    bus.delayed_data  = '0;
    @(negedge clk);
    checkResetValues(tag);
    rst = 1'b0;
    modelReset();
  endtask

  // Random one-cycle stimulus, biased towards retiring outstanding issues so
  // runs spend time in SYNC/LAG before an error makes them absorbing.
  task automatic randomCycle();
    logic [NI-1:0] o, d;
    logic [DW-1:0] od, dd;
    int off, r, j;
    o = '0; d = '0;
    if ($urandom_range(0, 2) == 0) o[$urandom_range(0, NI-1)] = 1'b1;
    r = $urandom_range(0, 9);
    if (r < 6) begin
      off = $urandom_range(0, NI-1);
      for (int k = 0; k < NI; k++) begin
        j = (off + k) % NI;
        if (d == '0 && m_lag[j] > 0) d[j] = 1'b1;
      end
    end else if (r == 9) begin
      d[$urandom_range(0, NI-1)] = 1'b1;
    end
    od = {$urandom, $urandom};
    dd = {$urandom, $urandom};
    if (d[0] && $urandom_range(0, 9) != 0) begin
      if (m_q.size() != 0) dd = m_q[0];
      else if (o[0]) dd = od;
    end
    applyStimulus("rand", o, d, od, dd);
  endtask

  initial begin
    bus.orig_instr    = '0;
    bus.delayed_instr = '0;
    bus.orig_data     = '0;
    bus.delayed_data  = '0;
    modelReset();

    // Reset state
    doReset("reset");

    // Matched push then pop
    applyStimulus("match0", 4'b0001, 4'b0000, 64'hA5, 64'h0);
    applyStimulus("match1", 4'b0000, 4'b0001, 64'h0, 64'hA5);

    // Data mismatch, held in ERR
    doReset("reset2");
    applyStimulus("mism0", 4'b0001, 4'b0000, 64'hA5, 64'h0);
    applyStimulus("mism1", 4'b0000, 4'b0001, 64'h0, 64'h5A);
    applyStimulus("mism_hold0", 4'b0000, 4'b0000, 64'h0, 64'h0);
    applyStimulus("mism_hold1", 4'b0000, 4'b0000, 64'h0, 64'h0);

    // Lag beyond MAX_LAG
    doReset("reset3");
    applyStimulus("over0", 4'b0010, 4'b0000, 64'h0, 64'h0);
    applyStimulus("over1", 4'b0010, 4'b0000, 64'h0, 64'h0);

    // Negative lag
    doReset("reset4");
    applyStimulus("neg0", 4'b0000, 4'b0100, 64'h0, 64'h0);

    // Bypass with equal data, then reset in the middle of LAG
    doReset("reset5");
    for (int c = 0; c < 5; c++) begin
      logic [DW-1:0] w;
      w = {$urandom, $urandom};
      applyStimulus("bypass", 4'b0001, 4'b0001, w, w);
    end
    applyStimulus("prelag", 4'b0001, 4'b0000, 64'h1234, 64'h0);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    bus.orig_instr    = '0;
    bus.delayed_instr = '0;
    rst = 1'b0;
    modelReset();
    applyStimulus("postrst", 4'b0000, 4'b0000, 64'h0, 64'h0);

    // Randomized episodes
    for (int ep = 0; ep < 30; ep++) begin
      doReset("rand_rst");
      for (int c = 0; c < 40; c++) randomCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
